alu_seq_driver: RTL and testbench
=================================

ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

Interface
REQ-001 Parameter: DEPTH, default 4, response buffer depth and max outstanding commands (power of 2, >=4).
REQ-002 Parameter: TAG_W, default 2, command tag width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge.
REQ-007 cmd_a, cmd_b  in  4 each  operands.
REQ-008 cmd_op  in  2  opcode: 0 add, 1 mul, 2 sub, 3 and.
REQ-009 cmd_tag  in  TAG_W  user tag, returned with result.
REQ-010 alu_a, alu_b  out  4 each  registered operands to downstream 2-stage sequential ALU.
REQ-011 alu_op  out  2  registered opcode to the ALU.
REQ-012 alu_out  in  8  ALU result.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at rising edge.
REQ-015 rsp_data  out  8  result; rsp_tag  out  TAG_W  matching tag.
REQ-016 chk_err  out  1  sticky result-mismatch flag.

Function
REQ-017 Accepted command SHALL load alu_a/alu_b/alu_op at the accepting edge N (issue); registers hold value when idle.
REQ-018 Result of a command issued at edge N SHALL be captured from alu_out at edge N+3 via a 3-stage valid/tag shift pipeline.
REQ-019 Captured results SHALL enter a DEPTH-entry FIFO in issue order; rsp_valid = FIFO non-empty; rsp_data/rsp_tag = head entry.
REQ-020 cmd_ready SHALL be high iff (in-flight count + FIFO occupancy) < DEPTH; derived from registered state only, never from cmd_valid.
REQ-021 Back-to-back issue every cycle SHALL be supported while credit remains; no result ever dropped.
REQ-022 Simultaneous capture and pop SHALL leave occupancy unchanged; pop frees one credit visible the following cycle.
REQ-023 Pop on empty FIFO and accept with cmd_ready low SHALL have no effect.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.

Reset
REQ-025 On rst: alu_a, alu_b, alu_op = 0; pipeline valids = 0; FIFO empty; rsp_valid = 0; chk_err = 0; cmd_ready = 1 after release.
REQ-026 Reset mid-operation SHALL discard all in-flight and buffered results; no stale response after release.

Configuration
REQ-027 Macro ALU_SEQ_DRIVER_CHECK_EN: when defined, golden model computes expected 8-bit result per command (add/mul zero-extended, sub 8-bit two's-complement wrap, and zero-extended), carries it in the pipeline, compares at capture, sets chk_err sticky on mismatch.
REQ-028 Without the macro, model and comparison logic SHALL be absent and chk_err tied to 0.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_ADD..OP_AND), operand width 4, result width 8.
REQ-030 Response buffer SHALL be sub-module alu_rsp_fifo (parameter DEPTH, width 8+TAG_W).

Verification
REQ-031 Issue add 3+4 tag 1 -> rsp_data 0x07, rsp_tag 1, captured exactly 3 edges after issue.
REQ-032 Issue sub 2-5, mul 15*15, and 0xA&0x6 back-to-back -> responses 0xFD, 0xE1, 0x02 in order.
REQ-033 rsp_ready=0, offer 6 commands -> exactly 4 accepted, cmd_ready low; release rsp_ready -> 4 correct responses, then remaining 2 accepted.
REQ-034 Continuous issue with rsp_ready=1 for 20 cycles -> one response per cycle after fill, cmd_ready never drops.
REQ-035 Assert rst with 3 in flight and 2 buffered -> rsp_valid 0 next cycle, no responses after release.
REQ-036 With ALU_SEQ_DRIVER_CHECK_EN, force alu_out to 0x00 for add 1+1 -> chk_err high at capture edge and stays high until rst.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, operand/result widths and the reference result function.
// The function is only instantiated by the optional result checker.
package alu_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,
    OP_AND = 2'd3
  } alu_op_e;

  // Operands are widened first so the multiply and the subtract wrap in 8 bits.
  function automatic logic [RES_W-1:0] alu_golden(input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b,
                                                  input logic [1:0]        op);
    logic [RES_W-1:0] ea;
    logic [RES_W-1:0] eb;
    logic [RES_W-1:0] res;
    ea  = {{(RES_W-OPND_W){1'b0}}, a};
    eb  = {{(RES_W-OPND_W){1'b0}}, b};
    res = '0;
    case (alu_op_e'(op))
      OP_ADD:  res = ea + eb;
      OP_MUL:  res = ea * eb;
      OP_SUB:  res = ea - eb;
      OP_AND:  res = ea & eb;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response buffer, DEPTH entries; head is a combinational read, occupancy updates on the clock edge.
// An extra pointer bit separates full from empty; push when full and pop when empty are ignored.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/alu_seq_driver.sv
// Drives a 2-stage ALU: result captured 3 edges after issue into an in-order response FIFO.
// cmd_ready is credit based (in flight + buffered < DEPTH); ALU_SEQ_DRIVER_CHECK_EN adds a golden-model checker.
module alu_seq_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [RES_W-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              chk_err
);

  localparam int CW = $clog2(DEPTH) + 2;
  localparam int FW = RES_W + TAG_W;

  logic                   accept;
  logic [2:0]             pipe_vld;
  logic [TAG_W-1:0]       pipe_tag [3];
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_empty;
  logic [FW-1:0]          fifo_head;
  logic [CW-1:0]          used;

  assign accept = cmd_valid & cmd_ready;

  // Every accepted command holds one credit until its response is popped.
  assign used = CW'(pipe_vld[0]) + CW'(pipe_vld[1]) + CW'(pipe_vld[2]) + CW'(fifo_count);
  assign cmd_ready = (used < CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      pipe_vld <= '0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      pipe_vld <= {pipe_vld[1:0], accept};
    end
  end

  // Tags travel alongside the valid bits; only stages with a valid bit are ever consumed.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= cmd_tag;
    pipe_tag[1] <= pipe_tag[0];
    pipe_tag[2] <= pipe_tag[1];
  end

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_vld[2]),
    .push_dat ({alu_out, pipe_tag[2]}),
    .pop      (rsp_ready),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = fifo_head[FW-1:TAG_W];
  assign rsp_tag   = fifo_head[TAG_W-1:0];

`ifdef ALU_SEQ_DRIVER_CHECK_EN
  logic [RES_W-1:0] pipe_exp [3];

  always_ff @(posedge clk) begin
    pipe_exp[0] <= alu_golden(cmd_a, cmd_b, cmd_op);
    pipe_exp[1] <= pipe_exp[0];
    pipe_exp[2] <= pipe_exp[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (pipe_vld[2] && (alu_out != pipe_exp[2])) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench: DEPTH=4 instance for latency/ordering/credit checks, DEPTH=8 instance for streaming and flush.
module tb_alu_seq_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       force_zero;

  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, chk_err;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [1:0] cmd_op, cmd_tag, alu_op, rsp_tag;
  logic [7:0] alu_out, alu_s1, rsp_data;

  logic       w_cmd_valid, w_cmd_ready, w_rsp_valid, w_rsp_ready, w_chk_err;
  logic [3:0] w_cmd_a, w_cmd_b, w_alu_a, w_alu_b;
  logic [1:0] w_cmd_op, w_cmd_tag, w_alu_op, w_rsp_tag;
  logic [7:0] w_alu_out, w_alu_s1, w_rsp_data;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rq_data[$];
  logic [1:0] rq_tag[$];
  logic [7:0] wq_data[$];
  logic [1:0] wq_tag[$];
  int         wq_step[$];

  always #5 clk = ~clk;

  alu_seq_driver #(.DEPTH(4), .TAG_W(2)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .chk_err(chk_err)
  );

  alu_seq_driver #(.DEPTH(8), .TAG_W(2)) u_dut_wide (
    .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
    .cmd_a(w_cmd_a), .cmd_b(w_cmd_b), .cmd_op(w_cmd_op), .cmd_tag(w_cmd_tag),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op), .alu_out(w_alu_out),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_tag(w_rsp_tag),
    .chk_err(w_chk_err)
  );

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      2'd0:    return ea + eb;
      2'd1:    return ea * eb;
      2'd2:    return ea - eb;
      default: return ea & eb;
    endcase
  endfunction

  // Two-stage downstream ALUs; force_zero corrupts the first one's output.
  always @(posedge clk) begin
    alu_s1    <= alu_ref(alu_a, alu_b, alu_op);
    alu_out   <= force_zero ? 8'h00 : alu_s1;
    w_alu_s1  <= alu_ref(w_alu_a, w_alu_b, w_alu_op);
    w_alu_out <= w_alu_s1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [1:0] tag, output logic acc);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    acc       = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int budget;
    budget = 40;
    rq_data.delete();
    rq_tag.delete();
    rsp_ready = 1'b1;
    while (rq_data.size() < n && budget > 0) begin
      if (rsp_valid) begin
        rq_data.push_back(rsp_data);
        rq_tag.push_back(rsp_tag);
      end
      @(negedge clk);
      budget--;
    end
    rsp_ready = 1'b0;
    check_eq("drain_count", rq_data.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   nacc;
    int   seen;
    logic [3:0] ta [6] = '{4'h1, 4'h3, 4'h9, 4'hF, 4'hF, 4'h7};
    logic [3:0] tb [6] = '{4'h2, 4'h5, 4'h4, 4'h9, 4'hF, 4'h9};
    logic [1:0] to [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int         tr [6] = '{'h03, 'h0F, 'h05, 'h09, 'h1E, 'h3F};

    rst = 1'b1; force_zero = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b0;
    w_cmd_valid = 1'b0; w_cmd_a = '0; w_cmd_b = '0; w_cmd_op = '0; w_cmd_tag = '0; w_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_alu_a", 32'(alu_a), 0);
    check_eq("rst_alu_b", 32'(alu_b), 0);
    check_eq("rst_alu_op", 32'(alu_op), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_chk_err", 32'(chk_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 1);

    // add 3+4 tag 1: response must appear exactly three edges after issue
    offer(4'h3, 4'h4, 2'd0, 2'd1, acc);
    check_eq("t1_acc", 32'(acc), 1);
    cmd_a = 4'h9; cmd_b = 4'h9; cmd_op = 2'd3;
    check_eq("t1_alu_a", 32'(alu_a), 3);
    check_eq("t1_alu_b", 32'(alu_b), 4);
    check_eq("t1_alu_op", 32'(alu_op), 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("t1_early", 32'(rsp_valid), 0);
      @(negedge clk);
    end
    check_eq("t1_capture", 32'(rsp_valid), 1);
    check_eq("t1_data", 32'(rsp_data), 'h07);
    check_eq("t1_tag", 32'(rsp_tag), 1);
    check_eq("t1_hold_a", 32'(alu_a), 3);
    drain(1);
    check_eq("t1_popped", 32'(rsp_valid), 0);

    // back-to-back sub, mul, and
    offer(4'h2, 4'h5, 2'd2, 2'd2, acc);
    check_eq("t2_acc0", 32'(acc), 1);
    offer(4'hF, 4'hF, 2'd1, 2'd3, acc);
    check_eq("t2_acc1", 32'(acc), 1);
    offer(4'hA, 4'h6, 2'd3, 2'd0, acc);
    check_eq("t2_acc2", 32'(acc), 1);
    drain(3);
    check_eq("t2_sub", 32'(rq_data[0]), 'hFD);
    check_eq("t2_mul", 32'(rq_data[1]), 'hE1);
    check_eq("t2_and", 32'(rq_data[2]), 'h02);
    check_eq("t2_tags", 32'({rq_tag[0], rq_tag[1], rq_tag[2]}), 'b10_11_00);

    // credit exhaustion with the consumer stalled
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      offer(ta[i], tb[i], to[i], 2'(i), acc);
      if (acc) nacc++;
    end
    check_eq("t3_accepted", nacc, 4);
    check_eq("t3_ready_low", 32'(cmd_ready), 0);
    repeat (4) @(negedge clk);
    check_eq("t3_still_low", 32'(cmd_ready), 0);
    check_eq("t3_buffered", 32'(rsp_valid), 1);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_data", 32'(rq_data[i]), tr[i]);
      check_eq("t3_tag", 32'(rq_tag[i]), i);
    end
    check_eq("t3_ready_back", 32'(cmd_ready), 1);
    offer(ta[4], tb[4], to[4], 2'd0, acc);
    check_eq("t3_acc4", 32'(acc), 1);
    offer(ta[5], tb[5], to[5], 2'd1, acc);
    check_eq("t3_acc5", 32'(acc), 1);
    drain(2);
    check_eq("t3_data4", 32'(rq_data[0]), tr[4]);
    check_eq("t3_data5", 32'(rq_data[1]), tr[5]);

    // streaming on the DEPTH=8 instance
    w_rsp_ready = 1'b1;
    for (int s = 0; s < 30; s++) begin
      if (s < 20) begin
        w_cmd_valid = 1'b1;
        w_cmd_a = 4'(s); w_cmd_b = 4'(s + 5); w_cmd_op = 2'(s); w_cmd_tag = 2'(s);
        check_eq("t4_ready", 32'(w_cmd_ready), 1);
      end else begin
        w_cmd_valid = 1'b0;
      end
      if (w_rsp_valid) begin
        wq_data.push_back(w_rsp_data);
        wq_tag.push_back(w_rsp_tag);
        wq_step.push_back(s);
      end
      @(negedge clk);
    end
    check_eq("t4_count", wq_data.size(), 20);
    for (int j = 0; j < 20; j++) begin
      check_eq("t4_rsp", 32'({wq_tag[j], wq_data[j]}), 32'({2'(j), alu_ref(4'(j), 4'(j + 5), 2'(j))}));
      check_eq("t4_step", wq_step[j], j + 4);
    end

    // reset with 3 in flight and 2 buffered
    w_rsp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      w_cmd_valid = 1'b1;
      w_cmd_a = 4'(s); w_cmd_b = 4'h1; w_cmd_op = 2'd0; w_cmd_tag = 2'(s);
      @(negedge clk);
    end
    w_cmd_valid = 1'b0;
    check_eq("t5_buffered", 32'(w_rsp_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_flush", 32'(w_rsp_valid), 0);
    check_eq("t5_alu_a", 32'(w_alu_a), 0);
    rst = 1'b0;
    w_rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (w_rsp_valid) seen++;
    end
    check_eq("t5_stale", seen, 0);
    check_eq("t5_ready", 32'(w_cmd_ready), 1);
    w_rsp_ready = 1'b0;

    check_eq("chk_clean", 32'(chk_err), 0);
    check_eq("chk_clean_w", 32'(w_chk_err), 0);

`ifdef ALU_SEQ_DRIVER_CHECK_EN
    force_zero = 1'b1;
    offer(4'h1, 4'h1, 2'd0, 2'd1, acc);
    for (int k = 0; k < 3; k++) begin
      check_eq("t6_pre", 32'(chk_err), 0);
      @(negedge clk);
    end
    check_eq("t6_set", 32'(chk_err), 1);
    force_zero = 1'b0;
    drain(1);
    check_eq("t6_bad_data", 32'(rq_data[0]), 'h00);
    offer(4'h2, 4'h2, 2'd0, 2'd2, acc);
    drain(1);
    check_eq("t6_good_data", 32'(rq_data[0]), 'h04);
    check_eq("t6_sticky", 32'(chk_err), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_cleared", 32'(chk_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
